// File: rtl/regfile_writeback_queue_if.sv
// rtl/regfile_writeback_queue_if.sv - write request, register file write and bypass lookup signals
interface regfile_writeback_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [4:0]    in_reg;
  logic [31:0]   in_data;
  logic          wb_hold;
  logic [4:0]    write_reg;
  logic [31:0]   write_data;
  logic          regWrite;
  logic [4:0]    look_reg_1;
  logic [4:0]    look_reg_2;
  logic          hit_1;
  logic          hit_2;
  logic [31:0]   fwd_data_1;
  logic [31:0]   fwd_data_2;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_reg, in_data, wb_hold, look_reg_1, look_reg_2,
    input  in_ready, write_reg, write_data, regWrite,
    input  hit_1, hit_2, fwd_data_1, fwd_data_2, count
  );

  modport slave (
    input  in_valid, in_reg, in_data, wb_hold, look_reg_1, look_reg_2,
    output in_ready, write_reg, write_data, regWrite,
    output hit_1, hit_2, fwd_data_1, fwd_data_2, count
  );
endinterface

// File: rtl/regfile_writeback_queue.sv
// rtl/regfile_writeback_queue.sv - circular FIFO of pending register writes with bypass lookup
module regfile_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  regfile_writeback_queue_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    reg_mem  [DEPTH];
  logic [31:0]   data_mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;

  logic not_empty;
  logic push;
  logic pop;

  assign not_empty    = ~rst & (cnt != '0);
  assign bus.in_ready = ~rst & (cnt < CW'(DEPTH));
  assign bus.regWrite = not_empty & ~bus.wb_hold;
  assign bus.count    = cnt;

  assign push = bus.in_valid & bus.in_ready;
  assign pop  = bus.regWrite;

  assign bus.write_reg  = not_empty ? reg_mem[head]  : 5'd0;
  assign bus.write_data = not_empty ? data_mem[head] : 32'd0;

  // Walk oldest to youngest so the last match found is the youngest pending write.
  function automatic logic [32:0] lookup(input logic [4:0] key);
    logic [32:0]   res;
    logic [PW-1:0] idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (CW'(i) < cnt && reg_mem[idx] == key) begin
        res = {1'b1, data_mem[idx]};
      end
    end
    return res;
  endfunction

  logic [32:0] look_1;
  logic [32:0] look_2;

  always_comb begin
    look_1 = '0;
    look_2 = '0;
    if (!rst) begin
      look_1 = lookup(bus.look_reg_1);
      look_2 = lookup(bus.look_reg_2);
    end
  end

  assign bus.hit_1      = look_1[32];
  assign bus.fwd_data_1 = look_1[31:0];
  assign bus.hit_2      = look_2[32];
  assign bus.fwd_data_2 = look_2[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage is qualified by count everywhere, so it carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      reg_mem[tail]  <= bus.in_reg;
      data_mem[tail] <= bus.in_data;
    end
  end
endmodule

// File: tb/tb_regfile_writeback_queue.sv
// tb/tb_regfile_writeback_queue.sv - randomized and directed checks against a queue-based model
module tb_regfile_writeback_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_writeback_queue_if #(.DEPTH(DEPTH)) bus();

  regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  ent_t model_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  function automatic logic [32:0] model_look(input logic [4:0] key);
    logic [32:0] res = '0;
    if (rst) return res;
    foreach (model_q[i]) if (model_q[i].r == key) res = {1'b1, model_q[i].d};
    return res;
  endfunction

  function automatic logic model_ready();
    return !rst && model_q.size() < DEPTH;
  endfunction

  function automatic logic model_write();
    return !rst && model_q.size() > 0 && !bus.wb_hold;
  endfunction

  // Apply inputs at the falling edge and compare every output against the model.
  task automatic drive(input logic r, input logic v, input logic [4:0] ri, input logic [31:0] di,
                       input logic hold, input logic [4:0] l1, input logic [4:0] l2);
    logic [32:0] e1, e2;
    logic        ne;
    @(negedge clk);
    rst            = r;
    bus.in_valid   = v;
    bus.in_reg     = ri;
    bus.in_data    = di;
    bus.wb_hold    = hold;
    bus.look_reg_1 = l1;
    bus.look_reg_2 = l2;
    #1;
    ne = !rst && model_q.size() > 0;
    e1 = model_look(l1);
    e2 = model_look(l2);
    chk("in_ready",   bus.in_ready,   model_ready());
    chk("regWrite",   bus.regWrite,   model_write());
    chk("write_reg",  bus.write_reg,  ne ? model_q[0].r : 5'd0);
    chk("write_data", bus.write_data, ne ? model_q[0].d : 32'd0);
    chk("hit_1",      bus.hit_1,      e1[32]);
    chk("fwd_data_1", bus.fwd_data_1, e1[31:0]);
    chk("hit_2",      bus.hit_2,      e2[32]);
    chk("fwd_data_2", bus.fwd_data_2, e2[31:0]);
    chk("count",      bus.count,      model_q.size());
  endtask

  task automatic tick();
    logic acc, pop;
    acc = bus.in_valid && model_ready();
    pop = model_write();
    @(posedge clk);
    if (rst) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (acc) model_q.push_back('{r: bus.in_reg, d: bus.in_data});
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [4:0] ri, input logic [31:0] di,
                     input logic hold, input logic [4:0] l1, input logic [4:0] l2);
    drive(r, v, ri, di, hold, l1, l2);
    tick();
  endtask

  int pushed;

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_reg = '0; bus.in_data = '0;
    bus.wb_hold = 1'b0; bus.look_reg_1 = '0; bus.look_reg_2 = '0;

    cyc(1, 1, 5'd9, 32'h1234, 0, 5'd9, 5'd0);
    cyc(1, 0, 0, 0, 0, 0, 0);

    // Single push drains the following cycle.
    cyc(0, 1, 5'd3, 32'hA5, 0, 5'd3, 5'd3);
    drive(0, 0, 0, 0, 0, 5'd3, 5'd1);
    chk("req022_we",   bus.regWrite,   1'b1);
    chk("req022_reg",  bus.write_reg,  5'd3);
    chk("req022_data", bus.write_data, 32'h000000A5);
    chk("req022_hit",  bus.hit_1,      1'b1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("req022_cnt0", bus.count,    0);
    chk("req022_we0",  bus.regWrite, 1'b0);
    tick();

    // Fill under hold; fifth request must wait for space.
    for (int i = 0; i < 5; i++) cyc(0, 1, 5'(10 + i), 32'(100 + i), 1, 5'd12, 5'd14);
    drive(0, 1, 5'd14, 32'd104, 1, 5'd10, 5'd14);
    chk("req023_full_ready", bus.in_ready, 1'b0);
    chk("req023_full_cnt",   bus.count,    DEPTH);
    tick();
    for (int i = 0; i < 6; i++) cyc(0, i < 2, 5'd14, 32'd104, 0, 5'd14, 5'd10);

    // Youngest duplicate wins lookup.
    cyc(0, 1, 5'd7, 32'h11, 1, 0, 0);
    cyc(0, 1, 5'd2, 32'h22, 1, 0, 0);
    cyc(0, 1, 5'd7, 32'h33, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 5'd7, 5'd4);
    chk("req024_hit1", bus.hit_1,      1'b1);
    chk("req024_fwd1", bus.fwd_data_1, 32'h33);
    chk("req024_hit2", bus.hit_2,      1'b0);
    chk("req024_fwd2", bus.fwd_data_2, 32'h0);
    tick();

    // Top up to full, then stream with continuous valid.
    cyc(0, 1, 5'd1, 32'h44, 1, 0, 0);
    for (int i = 0; i < 12; i++) cyc(0, 1, 5'(i), 32'h500 + 32'(i), 0, 5'(i), 5'd7);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 0, 0, 0);

    // Reset with entries pending discards them.
    for (int i = 0; i < 3; i++) cyc(0, 1, 5'(20 + i), 32'(i), 1, 5'd20, 5'd21);
    cyc(1, 0, 0, 0, 0, 5'd20, 5'd21);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 5'd20, 5'd21);
      chk("req026_we", bus.regWrite, 1'b0);
      tick();
    end

    // Register 0 is an ordinary destination.
    cyc(0, 1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 5'd0);
    drive(0, 0, 0, 0, 0, 5'd0, 5'd0);
    chk("req027_we",   bus.regWrite,   1'b1);
    chk("req027_reg",  bus.write_reg,  5'd0);
    chk("req027_data", bus.write_data, 32'hFFFFFFFF);
    tick();

    pushed = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 59) == 0),
          ($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 7)),
          $urandom,
          ($urandom_range(0, 2) == 0),
          5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)));
    end
    for (int i = 0; i < DEPTH + 2; i++) cyc(0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
